// File: rtl/div_seq_if.sv
// Request/response bundle for div_seq: operands and mode in, busy/done/zero and Hi/Lo out.
interface div_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output div_start, div_signed, A, B,
    input  busy, div_done, div_zero, Hi, Lo
  );

  modport slave (
    input  div_start, div_signed, A, B,
    output busy, div_done, div_zero, Hi, Lo
  );
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per cycle; quotient to Lo, remainder to Hi.
module div_seq #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic     clk,
  input  logic     reset,
  div_seq_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sgn_q, sgn_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             zero_q, zero_d;

  logic             sgn_in;
  logic [WIDTH:0]   rem_sh;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    sgn_in  = bus.div_signed & SIGNED_EN;
    rem_sh  = {rem_q, dvd_q[WIDTH-1]};

    unique case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          if (bus.B == '0) begin
            zero_d = 1'b1;
            done_d = 1'b1;
          end else begin
            sgn_d   = sgn_in;
            sa_d    = bus.A[WIDTH-1];
            sb_d    = bus.B[WIDTH-1];
            dvd_d   = (sgn_in && bus.A[WIDTH-1]) ? -bus.A : bus.A;
            dvs_d   = (sgn_in && bus.B[WIDTH-1]) ? -bus.B : bus.B;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = CW'(WIDTH);
            zero_d  = 1'b0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        // Compare at WIDTH+1 bits; the difference always fits WIDTH bits, so a
        // WIDTH-bit subtraction is exact.
        if (rem_sh >= {1'b0, dvs_q}) begin
          rem_d = rem_sh[WIDTH-1:0] - dvs_q;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        lo_d    = (sgn_q && (sa_q != sb_q)) ? -quo_q : quo_q;
        hi_d    = (sgn_q && sa_q) ? -rem_q : rem_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.div_done = done_q;
  assign bus.div_zero = zero_q;
  assign bus.Hi       = hi_q;
  assign bus.Lo       = lo_q;
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: 32-bit signed instance plus two 8-bit instances.
module tb_div_seq;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) b32 ();
  div_seq_if #(.WIDTH(8))  b8s ();
  div_seq_if #(.WIDTH(8))  b8u ();

  div_seq #(.WIDTH(32), .SIGNED_EN(1'b1)) u32 (.clk(clk), .reset(reset), .bus(b32.slave));
  div_seq #(.WIDTH(8),  .SIGNED_EN(1'b1)) u8s (.clk(clk), .reset(reset), .bus(b8s.slave));
  div_seq #(.WIDTH(8),  .SIGNED_EN(1'b0)) u8u (.clk(clk), .reset(reset), .bus(b8u.slave));

  typedef struct {logic [31:0] lo; logic [31:0] hi; logic zero;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] b; logic s; logic [31:0] lo; logic [31:0] hi;} vec_t;
  typedef struct {bit u; logic [7:0] a; logic [7:0] b; logic s; logic [7:0] lo; logic [7:0] hi;} v8_t;

  exp_t sb32[$];
  exp_t sb8[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  localparam int BUDGET = 60;

  function automatic exp_t model32(logic [31:0] a, logic [31:0] b, logic s);
    longint na, nb, q, r;
    exp_t   e;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'({32'b0, a});
      nb = longint'({32'b0, b});
    end
    q = na / nb;
    r = na % nb;
    e.lo = q[31:0];
    e.hi = r[31:0];
    e.zero = 1'b0;
    return e;
  endfunction

  // Drive a start at the current negedge; returns at the negedge after the capture edge.
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
    b32.A = a; b32.B = b; b32.div_signed = s; b32.div_start = 1'b1;
    @(negedge clk);
    b32.div_start = 1'b0;
    b32.A = $urandom; b32.B = $urandom; b32.div_signed = 1'($urandom_range(0, 1));
  endtask

  task automatic wait32(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (!b32.div_done && edges < BUDGET) begin
      busy_cnt += int'(b32.busy);
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({b32.busy, b32.div_done, b32.div_zero, b32.Hi, b32.Lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_w32: got busy=%b done=%b zero=%b Hi=%h Lo=%h want all 0",
               b32.busy, b32.div_done, b32.div_zero, b32.Hi, b32.Lo);
    end
    n_cmp++;
    if ({b8s.busy, b8s.div_done, b8s.div_zero, b8s.Hi, b8s.Lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_w8s: got busy=%b done=%b zero=%b Hi=%h Lo=%h want all 0",
               b8s.busy, b8s.div_done, b8s.div_zero, b8s.Hi, b8s.Lo);
    end
    n_cmp++;
    if ({b8u.busy, b8u.div_done, b8u.div_zero, b8u.Hi, b8u.Lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_w8u: got busy=%b done=%b zero=%b Hi=%h Lo=%h want all 0",
               b8u.busy, b8u.div_done, b8u.div_zero, b8u.Hi, b8u.Lo);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_signed_basics;
    vec_t v[4] = '{
      '{32'd7,          32'd2,          1'b1, 32'd3,          32'd1},
      '{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF},
      '{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1},
      '{32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF}};
    int   e, bc;
    exp_t ex;
    foreach (v[i]) begin
      sb32.push_back('{v[i].lo, v[i].hi, 1'b0});
      start32(v[i].a, v[i].b, v[i].s);
      wait32(e, bc);
      ex = sb32.pop_front();
      n_cmp++;
      if (e != 33) begin
        n_bad++;
        $display("FAIL basic_latency[%0d]: got %0d edges want 33", i, e);
      end
      n_cmp++;
      if (bc != 33 || b32.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_busy[%0d]: got %0d busy cycles, busy@done=%b want 33, 0", i, bc, b32.busy);
      end
      n_cmp++;
      if ({b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
        n_bad++;
        $display("FAIL basic_result[%0d]: got Lo=%h Hi=%h zero=%b want Lo=%h Hi=%h zero=%b",
                 i, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
      end
      @(negedge clk);
      n_cmp++;
      if (b32.div_done !== 1'b0) begin
        n_bad++;
        $display("FAIL basic_done_pulse[%0d]: got done=%b a cycle later want 0", i, b32.div_done);
      end
    end
  endtask

  task automatic test_unsigned_vs_signed;
    vec_t v[3] = '{
      '{32'hFFFF_FFFE, 32'd2,          1'b0, 32'h7FFF_FFFF, 32'd0},
      '{32'hFFFF_FFFE, 32'd2,          1'b1, 32'hFFFF_FFFF, 32'd0},
      '{32'd5,         32'h8000_0000,  1'b0, 32'd0,         32'd5}};
    int   e, bc;
    exp_t ex;
    foreach (v[i]) begin
      sb32.push_back('{v[i].lo, v[i].hi, 1'b0});
      start32(v[i].a, v[i].b, v[i].s);
      wait32(e, bc);
      ex = sb32.pop_front();
      n_cmp++;
      if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
        n_bad++;
        $display("FAIL mode[%0d]: got edges=%0d Lo=%h Hi=%h zero=%b want edges=33 Lo=%h Hi=%h zero=%b",
                 i, e, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overflow_and_zero;
    int   e, bc;
    exp_t ex;
    sb32.push_back('{32'h8000_0000, 32'd0, 1'b0});
    start32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait32(e, bc);
    ex = sb32.pop_front();
    n_cmp++;
    if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
      n_bad++;
      $display("FAIL overflow: got edges=%0d Lo=%h Hi=%h zero=%b want edges=33 Lo=%h Hi=%h zero=%b",
               e, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
    end
    @(negedge clk);
    sb32.push_back('{32'd3, 32'd1, 1'b0});
    start32(32'd7, 32'd2, 1'b1);
    wait32(e, bc);
    ex = sb32.pop_front();
    n_cmp++;
    if ({b32.Lo, b32.Hi} !== {ex.lo, ex.hi}) begin
      n_bad++;
      $display("FAIL zero_prior: got Lo=%h Hi=%h want Lo=%h Hi=%h", b32.Lo, b32.Hi, ex.lo, ex.hi);
    end
    @(negedge clk);
    sb32.push_back('{32'd3, 32'd1, 1'b1});
    start32(32'd3, 32'd0, 1'b1);
    ex = sb32.pop_front();
    n_cmp++;
    if ({b32.div_done, b32.busy, b32.Lo, b32.Hi, b32.div_zero} !== {1'b1, 1'b0, ex.lo, ex.hi, ex.zero}) begin
      n_bad++;
      $display("FAIL div_by_zero: got done=%b busy=%b Lo=%h Hi=%h zero=%b want done=1 busy=0 Lo=%h Hi=%h zero=%b",
               b32.div_done, b32.busy, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
    end
    @(negedge clk);
    n_cmp++;
    if ({b32.div_done, b32.div_zero} !== 2'b01) begin
      n_bad++;
      $display("FAIL zero_hold: got done=%b zero=%b want done=0 zero=1", b32.div_done, b32.div_zero);
    end
    sb32.push_back(model32(32'd9, 32'd4, 1'b1));
    start32(32'd9, 32'd4, 1'b1);
    n_cmp++;
    if (b32.div_zero !== 1'b0 || b32.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_clear: got zero=%b busy=%b after capture want zero=0 busy=1", b32.div_zero, b32.busy);
    end
    wait32(e, bc);
    ex = sb32.pop_front();
    n_cmp++;
    if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
      n_bad++;
      $display("FAIL after_zero: got edges=%0d Lo=%h Hi=%h zero=%b want edges=33 Lo=%h Hi=%h zero=%b",
               e, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
    end
    @(negedge clk);
  endtask

  task automatic test_handshake;
    int   e;
    exp_t ex;
    sb32.push_back('{32'd14, 32'd2, 1'b0});
    start32(32'd100, 32'd7, 1'b1);
    e = 0;
    while (!b32.div_done && e < BUDGET) begin
      b32.div_start = (e == 9);
      if (e == 9) begin
        b32.A = 32'd1; b32.B = 32'd1; b32.div_signed = 1'b1;
      end
      @(negedge clk);
      e++;
    end
    b32.div_start = 1'b0;
    ex = sb32.pop_front();
    n_cmp++;
    if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
      n_bad++;
      $display("FAIL ignore_start: got edges=%0d Lo=%h Hi=%h zero=%b want edges=33 Lo=%h Hi=%h zero=%b",
               e, b32.Lo, b32.Hi, b32.div_zero, ex.lo, ex.hi, ex.zero);
    end
  endtask

  // Each new start is driven in the div_done cycle of the previous one.
  task automatic test_back_to_back;
    int          e, bc;
    exp_t        ex;
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = (i == 1) ? 32'd3 : $urandom;
      if (b == '0) b = 32'd1;
      s = 1'(i % 2);
      sb32.push_back(model32(a, b, s));
      start32(a, b, s);
      wait32(e, bc);
      ex = sb32.pop_front();
      n_cmp++;
      if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
        n_bad++;
        $display("FAIL b2b[%0d]: a=%h b=%h s=%b got edges=%0d Lo=%h Hi=%h want edges=33 Lo=%h Hi=%h",
                 i, a, b, s, e, b32.Lo, b32.Hi, ex.lo, ex.hi);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (b32.div_done !== 1'b0 || sb32.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_tail: got done=%b pending=%0d want done=0 pending=0", b32.div_done, sb32.size());
    end
  endtask

  task automatic test_reset_mid;
    int   e, bc;
    bit   seen;
    exp_t ex;
    sb32.push_back(model32(32'd1000, 32'd3, 1'b0));
    start32(32'd1000, 32'd3, 1'b0);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({b32.busy, b32.div_done, b32.Hi, b32.Lo} !== '0) begin
      n_bad++;
      $display("FAIL reset_abort: got busy=%b done=%b Hi=%h Lo=%h want all 0",
               b32.busy, b32.div_done, b32.Hi, b32.Lo);
    end
    sb32.delete();
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b32.div_done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL reset_no_done: got a div_done pulse after abort want none");
    end
    sb32.push_back(model32(32'hFFFF_FC18, 32'd3, 1'b1));
    start32(32'hFFFF_FC18, 32'd3, 1'b1);
    wait32(e, bc);
    ex = sb32.pop_front();
    n_cmp++;
    if (e != 33 || {b32.Lo, b32.Hi, b32.div_zero} !== {ex.lo, ex.hi, ex.zero}) begin
      n_bad++;
      $display("FAIL reset_fresh: got edges=%0d Lo=%h Hi=%h want edges=33 Lo=%h Hi=%h",
               e, b32.Lo, b32.Hi, ex.lo, ex.hi);
    end
    @(negedge clk);
  endtask

  task automatic test_width8;
    v8_t v[4] = '{
      '{1'b0, 8'h81, 8'h05, 1'b1, 8'hE7, 8'hFE},
      '{1'b1, 8'hF0, 8'h10, 1'b1, 8'h0F, 8'h00},
      '{1'b1, 8'hFF, 8'h80, 1'b0, 8'h01, 8'h7F},
      '{1'b0, 8'h80, 8'hFF, 1'b1, 8'h80, 8'h00}};
    int         e;
    logic       dn;
    logic [7:0] lo, hi;
    exp_t       ex;
    foreach (v[i]) begin
      sb8.push_back('{{24'b0, v[i].lo}, {24'b0, v[i].hi}, 1'b0});
      if (v[i].u) begin
        b8u.A = v[i].a; b8u.B = v[i].b; b8u.div_signed = v[i].s; b8u.div_start = 1'b1;
      end else begin
        b8s.A = v[i].a; b8s.B = v[i].b; b8s.div_signed = v[i].s; b8s.div_start = 1'b1;
      end
      @(negedge clk);
      b8u.div_start = 1'b0;
      b8s.div_start = 1'b0;
      e = 0;
      dn = v[i].u ? b8u.div_done : b8s.div_done;
      while (!dn && e < BUDGET) begin
        @(negedge clk);
        e++;
        dn = v[i].u ? b8u.div_done : b8s.div_done;
      end
      lo = v[i].u ? b8u.Lo : b8s.Lo;
      hi = v[i].u ? b8u.Hi : b8s.Hi;
      ex = sb8.pop_front();
      n_cmp++;
      if (e != 9 || {lo, hi} !== {ex.lo[7:0], ex.hi[7:0]}) begin
        n_bad++;
        $display("FAIL w8[%0d]: got edges=%0d Lo=%h Hi=%h want edges=9 Lo=%h Hi=%h",
                 i, e, lo, hi, ex.lo[7:0], ex.hi[7:0]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1;
    b32.div_start = 1'b0; b32.div_signed = 1'b0; b32.A = '0; b32.B = '0;
    b8s.div_start = 1'b0; b8s.div_signed = 1'b0; b8s.A = '0; b8s.B = '0;
    b8u.div_start = 1'b0; b8u.div_signed = 1'b0; b8u.A = '0; b8u.B = '0;
    test_reset();
    test_signed_basics();
    test_unsigned_vs_signed();
    test_overflow_and_zero();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    test_width8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
